// File: rtl/branch_predictor_if.sv
// Branch predictor interface: bundles the fetch-side lookup, the EX-side
// resolution/training inputs, the redirect outputs and the statistics
// counters. The pipeline drives it through the master modport and the
// predictor consumes it through the slave modport.
//   IF  : if_pc (to predictor), if_pred_taken / if_next_pc (from predictor)
//   EX  : ex_valid, ex_pc, ex_is_cti, ex_taken, ex_target, ex_pred_taken,
//         ex_pred_target (to predictor)
//   Out : mispredict, redirect_pc, stat_cti, stat_miss (from predictor)
interface branch_predictor_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] if_pc;
  logic              if_pred_taken;
  logic [ADDR_W-1:0] if_next_pc;
  logic              ex_valid;
  logic [ADDR_W-1:0] ex_pc;
  logic              ex_is_cti;
  logic              ex_taken;
  logic [ADDR_W-1:0] ex_target;
  logic              ex_pred_taken;
  logic [ADDR_W-1:0] ex_pred_target;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
  logic [31:0]       stat_cti;
  logic [31:0]       stat_miss;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_is_cti, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  if_pred_taken, if_next_pc, mispredict, redirect_pc,
           stat_cti, stat_miss
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_is_cti, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output if_pred_taken, if_next_pc, mispredict, redirect_pc,
           stat_cti, stat_miss
  );
endinterface

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: a direct-mapped BTB whose entries carry a
// saturating direction counter. Fetch looks up if_pc combinationally and gets
// a predicted next PC; EX resolves the real next PC, flags a mispredict when
// it differs from what fetch followed, and trains the table on the clock edge.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset (clears table and statistics)
//   bp   : branch_predictor_if slave (lookup, resolution, redirect, stats)
module branch_predictor #(
  parameter int ENTRIES  = 16,
  parameter int CNT_BITS = 2,
  parameter int ADDR_W   = 32
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CNT_BITS-1:0] TAKEN_TH = CNT_BITS'(1) << (CNT_BITS - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};

  // Saturating increment of a direction counter.
  function automatic logic [CNT_BITS-1:0] cnt_inc(input logic [CNT_BITS-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_BITS'(1);
  endfunction

  // Saturating decrement of a direction counter.
  function automatic logic [CNT_BITS-1:0] cnt_dec(input logic [CNT_BITS-1:0] c);
    return (c == {CNT_BITS{1'b0}}) ? c : c - CNT_BITS'(1);
  endfunction

  // Table storage (flops, so combinational read is fine)
  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [ADDR_W-1:0]   target_q [ENTRIES];
  logic [CNT_BITS-1:0] cnt_q    [ENTRIES];

  logic [31:0] stat_cti_q, stat_cti_d;
  logic [31:0] stat_miss_q, stat_miss_d;

  // Lookup side
  logic [IDX_W-1:0]  if_idx_s;
  logic [TAG_W-1:0]  if_tag_s;
  logic              if_hit_s;
  logic              if_pred_taken_s;
  logic [ADDR_W-1:0] if_next_pc_s;

  // Resolution / training side
  logic [IDX_W-1:0]    ex_idx_s;
  logic [TAG_W-1:0]    ex_tag_s;
  logic                ex_hit_s;
  logic                act_taken_s;
  logic [ADDR_W-1:0]   act_next_s;
  logic                mispredict_s;
  logic                upd_we_s;
  logic                valid_d;
  logic [TAG_W-1:0]    tag_d;
  logic [ADDR_W-1:0]   target_d;
  logic [CNT_BITS-1:0] cnt_d;

  // The carried direction bit is implied by ex_pred_target, so it is not
  // needed for the mispredict decision.
  logic unused_s;
  assign unused_s = bp.ex_pred_taken;

  assign if_idx_s = bp.if_pc[IDX_W+1:2];
  assign if_tag_s = bp.if_pc[ADDR_W-1:IDX_W+2];
  assign ex_idx_s = bp.ex_pc[IDX_W+1:2];
  assign ex_tag_s = bp.ex_pc[ADDR_W-1:IDX_W+2];

  // Fetch lookup: reads pre-update contents, no bypass from a same-cycle write.
  always_comb begin
    if_hit_s        = valid_q[if_idx_s] && (tag_q[if_idx_s] == if_tag_s);
    if_pred_taken_s = if_hit_s && (cnt_q[if_idx_s] >= TAKEN_TH);
    if (if_pred_taken_s) begin
      if_next_pc_s = target_q[if_idx_s];
    end else begin
      if_next_pc_s = bp.if_pc + ADDR_W'(4);
    end
  end

  // EX resolution: any difference between followed and actual next PC is a
  // mispredict, which also catches a non-CTI that was predicted taken.
  always_comb begin
    act_taken_s = bp.ex_is_cti && bp.ex_taken;
    if (act_taken_s) begin
      act_next_s = bp.ex_target;
    end else begin
      act_next_s = bp.ex_pc + ADDR_W'(4);
    end
    mispredict_s = bp.ex_valid && (bp.ex_pred_target != act_next_s);
  end

  // Next value of the single entry addressed by EX, plus statistics.
  always_comb begin
    ex_hit_s    = valid_q[ex_idx_s] && (tag_q[ex_idx_s] == ex_tag_s);
    upd_we_s    = 1'b0;
    valid_d     = valid_q[ex_idx_s];
    tag_d       = tag_q[ex_idx_s];
    target_d    = target_q[ex_idx_s];
    cnt_d       = cnt_q[ex_idx_s];
    stat_cti_d  = stat_cti_q;
    stat_miss_d = stat_miss_q;
    if (bp.ex_valid) begin
      if (bp.ex_is_cti) begin
        stat_cti_d = stat_cti_q + 32'd1;
        if (ex_hit_s) begin
          upd_we_s = 1'b1;
          if (bp.ex_taken) begin
            cnt_d    = cnt_inc(cnt_q[ex_idx_s]);
            target_d = bp.ex_target;
          end else begin
            cnt_d = cnt_dec(cnt_q[ex_idx_s]);
          end
        end else if (bp.ex_taken) begin
          // Allocate over whatever occupied the slot, weakly taken.
          upd_we_s = 1'b1;
          valid_d  = 1'b1;
          tag_d    = ex_tag_s;
          target_d = bp.ex_target;
          cnt_d    = TAKEN_TH;
        end else begin
          upd_we_s = 1'b0;
        end
      end else if (ex_hit_s) begin
        // A non-CTI matched an entry: evict the alias.
        upd_we_s = 1'b1;
        valid_d  = 1'b0;
      end else begin
        upd_we_s = 1'b0;
      end
      if (mispredict_s) begin
        stat_miss_d = stat_miss_q + 32'd1;
      end else begin
        stat_miss_d = stat_miss_q;
      end
    end else begin
      upd_we_s = 1'b0;
    end
  end

  // Table state: reset clears every field, otherwise write the EX entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= {TAG_W{1'b0}};
        target_q[i] <= {ADDR_W{1'b0}};
        cnt_q[i]    <= {CNT_BITS{1'b0}};
      end
    end else if (upd_we_s) begin
      valid_q[ex_idx_s]  <= valid_d;
      tag_q[ex_idx_s]    <= tag_d;
      target_q[ex_idx_s] <= target_d;
      cnt_q[ex_idx_s]    <= cnt_d;
    end
  end

  // Statistics counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cti_q  <= 32'd0;
      stat_miss_q <= 32'd0;
    end else begin
      stat_cti_q  <= stat_cti_d;
      stat_miss_q <= stat_miss_d;
    end
  end

  assign bp.if_pred_taken = if_pred_taken_s;
  assign bp.if_next_pc    = if_next_pc_s;
  assign bp.mispredict    = mispredict_s;
  assign bp.redirect_pc   = act_next_s;
  assign bp.stat_cti      = stat_cti_q;
  assign bp.stat_miss     = stat_miss_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a 16-entry/2-bit instance and a
// 4-entry/3-bit instance driven through their interfaces.
module tb_branch_predictor;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  branch_predictor_if #(.ADDR_W(32)) bp16 ();
  branch_predictor_if #(.ADDR_W(32)) bp4 ();

  branch_predictor #(.ENTRIES(16), .CNT_BITS(2), .ADDR_W(32)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bp  (bp16)
  );

  branch_predictor #(.ENTRIES(4), .CNT_BITS(3), .ADDR_W(32)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bp  (bp4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex16(input logic v, input logic [31:0] pc, input logic cti,
                      input logic tk, input logic [31:0] tgt, input logic [31:0] ptgt);
    bp16.ex_valid       = v;
    bp16.ex_pc          = pc;
    bp16.ex_is_cti      = cti;
    bp16.ex_taken       = tk;
    bp16.ex_target      = tgt;
    bp16.ex_pred_taken  = (ptgt != pc + 32'd4);
    bp16.ex_pred_target = ptgt;
  endtask

  task automatic ex4(input logic v, input logic [31:0] pc, input logic cti,
                     input logic tk, input logic [31:0] tgt, input logic [31:0] ptgt);
    bp4.ex_valid       = v;
    bp4.ex_pc          = pc;
    bp4.ex_is_cti      = cti;
    bp4.ex_taken       = tk;
    bp4.ex_target      = tgt;
    bp4.ex_pred_taken  = (ptgt != pc + 32'd4);
    bp4.ex_pred_target = ptgt;
  endtask

  task automatic idle16();
    ex16(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h4);
  endtask

  task automatic idle4();
    ex4(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h4);
  endtask

  initial begin
    logic [31:0] pcs [4];
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bp16.if_pc = 32'h100;
    bp4.if_pc  = 32'h100;
    idle4();
    // EX activity during reset must not train or count
    ex16(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 32'h104);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle16();
    #1;
    chk("rst_pred", bp16.if_pred_taken, 32'd0);
    chk("rst_next", bp16.if_next_pc, 32'h104);
    chk("rst_cti", bp16.stat_cti, 32'd0);
    chk("rst_miss", bp16.stat_miss, 32'd0);

    // First taken resolution: mispredict and allocate; no same-cycle bypass
    ex16(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 32'h104);
    #1;
    chk("alloc_mis", bp16.mispredict, 32'd1);
    chk("alloc_redir", bp16.redirect_pc, 32'h80);
    chk("alloc_nobypass_pred", bp16.if_pred_taken, 32'd0);
    chk("alloc_nobypass_next", bp16.if_next_pc, 32'h104);
    tick();
    idle16();
    #1;
    chk("alloc_pred", bp16.if_pred_taken, 32'd1);
    chk("alloc_next", bp16.if_next_pc, 32'h80);
    chk("alloc_cti", bp16.stat_cti, 32'd1);
    chk("alloc_miss", bp16.stat_miss, 32'd1);

    // Two correct taken resolutions: cnt 2->3->3 (saturates)
    repeat (2) begin
      ex16(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 32'h80);
      #1;
      chk("tk_mis", bp16.mispredict, 32'd0);
      tick();
    end
    idle16();
    #1;
    chk("sat_pred", bp16.if_pred_taken, 32'd1);

    // Not-taken: 3->2 (still taken), 2->1 (flips), 1->0
    ex16(1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 32'h80);
    #1;
    chk("nt1_mis", bp16.mispredict, 32'd1);
    chk("nt1_redir", bp16.redirect_pc, 32'h104);
    tick();
    idle16();
    #1;
    chk("nt1_pred", bp16.if_pred_taken, 32'd1);
    ex16(1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 32'h80);
    #1;
    chk("nt2_mis", bp16.mispredict, 32'd1);
    tick();
    idle16();
    #1;
    chk("nt2_pred", bp16.if_pred_taken, 32'd0);
    chk("nt2_next", bp16.if_next_pc, 32'h104);
    ex16(1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 32'h104);
    #1;
    chk("nt3_mis", bp16.mispredict, 32'd0);
    tick();

    // cnt 0->1 with a new target: still not-taken; then 1->2 uses new target
    ex16(1'b1, 32'h100, 1'b1, 1'b1, 32'h90, 32'h104);
    #1;
    chk("tk4_redir", bp16.redirect_pc, 32'h90);
    tick();
    idle16();
    #1;
    chk("min_pred", bp16.if_pred_taken, 32'd0);
    ex16(1'b1, 32'h100, 1'b1, 1'b1, 32'h90, 32'h104);
    tick();
    idle16();
    #1;
    chk("newtgt_pred", bp16.if_pred_taken, 32'd1);
    chk("newtgt_next", bp16.if_next_pc, 32'h90);
    chk("train_cti", bp16.stat_cti, 32'd8);
    chk("train_miss", bp16.stat_miss, 32'd5);

    // Alias at 0x140 replaces the 0x100 entry
    ex16(1'b1, 32'h140, 1'b1, 1'b1, 32'h200, 32'h144);
    #1;
    chk("alias_redir", bp16.redirect_pc, 32'h200);
    tick();
    idle16();
    #1;
    chk("alias_old_pred", bp16.if_pred_taken, 32'd0);
    chk("alias_old_next", bp16.if_next_pc, 32'h104);
    bp16.if_pc = 32'h140;
    #1;
    chk("alias_new_next", bp16.if_next_pc, 32'h200);

    // Non-CTI hitting the entry: mispredict to pc+4 and evict
    ex16(1'b1, 32'h140, 1'b0, 1'b0, 32'h0, 32'h200);
    #1;
    chk("noncti_mis", bp16.mispredict, 32'd1);
    chk("noncti_redir", bp16.redirect_pc, 32'h144);
    tick();
    idle16();
    #1;
    chk("evict_pred", bp16.if_pred_taken, 32'd0);
    chk("evict_next", bp16.if_next_pc, 32'h144);
    chk("evict_cti", bp16.stat_cti, 32'd9);
    chk("evict_miss", bp16.stat_miss, 32'd7);

    // Not-taken CTI that misses: no allocation
    ex16(1'b1, 32'h108, 1'b1, 1'b0, 32'h700, 32'h10C);
    #1;
    chk("ntmiss_mis", bp16.mispredict, 32'd0);
    tick();
    idle16();
    bp16.if_pc = 32'h108;
    #1;
    chk("ntmiss_pred", bp16.if_pred_taken, 32'd0);
    bp16.if_pc = 32'hFFFF_FFFC;
    #1;
    chk("wrap_next", bp16.if_next_pc, 32'h0);

    // Same-cycle lookup and allocation of index 0
    bp16.if_pc = 32'h100;
    ex16(1'b1, 32'h100, 1'b1, 1'b1, 32'h40, 32'h104);
    #1;
    chk("same_next", bp16.if_next_pc, 32'h104);
    tick();
    idle16();
    #1;
    chk("same_after_next", bp16.if_next_pc, 32'h40);

    // Bubble with mispredicting contents: nothing happens
    ex16(1'b0, 32'h100, 1'b1, 1'b0, 32'h0, 32'h1234_5678);
    #1;
    chk("bubble_mis", bp16.mispredict, 32'd0);
    tick();
    idle16();
    #1;
    chk("bubble_pred", bp16.if_pred_taken, 32'd1);
    chk("bubble_cti", bp16.stat_cti, 32'd11);
    chk("bubble_miss", bp16.stat_miss, 32'd8);

    // Train four entries, then reset mid-run
    ex16(1'b1, 32'h104, 1'b1, 1'b1, 32'h400, 32'h108);
    tick();
    ex16(1'b1, 32'h10C, 1'b1, 1'b1, 32'h500, 32'h110);
    tick();
    ex16(1'b1, 32'h110, 1'b1, 1'b1, 32'h600, 32'h114);
    tick();
    idle16();
    bp16.if_pc = 32'h110;
    #1;
    chk("pre_rst_next", bp16.if_next_pc, 32'h600);
    rst = 1'b1;
    ex16(1'b1, 32'h100, 1'b1, 1'b1, 32'h40, 32'h104);
    tick();
    rst = 1'b0;
    idle16();
    pcs[0] = 32'h100;
    pcs[1] = 32'h104;
    pcs[2] = 32'h10C;
    pcs[3] = 32'h110;
    for (int i = 0; i < 4; i++) begin
      bp16.if_pc = pcs[i];
      #1;
      chk("midrst_pred", bp16.if_pred_taken, 32'd0);
      chk("midrst_next", bp16.if_next_pc, pcs[i] + 32'd4);
    end
    chk("midrst_cti", bp16.stat_cti, 32'd0);
    chk("midrst_miss", bp16.stat_miss, 32'd0);

    // 4-entry, 3-bit instance: threshold 4, saturation 7, index pc[3:2]
    bp4.if_pc = 32'h100;
    #1;
    chk("c3_rst_next", bp4.if_next_pc, 32'h104);
    ex4(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 32'h104);
    #1;
    chk("c3_alloc_mis", bp4.mispredict, 32'd1);
    tick();
    idle4();
    #1;
    chk("c3_alloc_next", bp4.if_next_pc, 32'h80);
    repeat (4) begin
      ex4(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 32'h80);
      #1;
      chk("c3_tk_mis", bp4.mispredict, 32'd0);
      tick();
    end
    idle4();
    #1;
    chk("c3_sat_pred", bp4.if_pred_taken, 32'd1);
    repeat (3) begin
      ex4(1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 32'h80);
      #1;
      chk("c3_nt_mis", bp4.mispredict, 32'd1);
      tick();
    end
    idle4();
    #1;
    chk("c3_th_pred", bp4.if_pred_taken, 32'd1);
    ex4(1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 32'h80);
    tick();
    idle4();
    #1;
    chk("c3_flip_pred", bp4.if_pred_taken, 32'd0);
    chk("c3_flip_next", bp4.if_next_pc, 32'h104);
    chk("c3_cti", bp4.stat_cti, 32'd9);
    chk("c3_miss", bp4.stat_miss, 32'd5);
    ex4(1'b1, 32'h110, 1'b1, 1'b1, 32'h300, 32'h114);
    tick();
    idle4();
    #1;
    chk("c3_alias_old_next", bp4.if_next_pc, 32'h104);
    bp4.if_pc = 32'h110;
    #1;
    chk("c3_alias_new_next", bp4.if_next_pc, 32'h300);
    chk("c3_alias_miss", bp4.stat_miss, 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor (BTB plus saturating-counter history) for the 5-stage RISC-V pipeline.
- Replaces always-not-taken fetch with a predicted next PC in IF.
- Accepts resolved branch/jump outcomes from EX, trains its table, flags mispredictions and supplies the redirect PC so the hazard logic flushes only on mispredict.

Parameters:
- ENTRIES, 16, number of table entries; power of two, >=2; IDX_W = log2(ENTRIES)
- CNT_BITS, 2, saturating counter width, >=1; TAKEN_TH = 2^(CNT_BITS-1)
- ADDR_W, 32, PC width; TAG_W = ADDR_W-IDX_W-2

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- if_pc  in  ADDR_W  PC being fetched
- if_pred_taken  out  1  prediction for if_pc (combinational from table)
- if_next_pc  out  ADDR_W  predicted next fetch PC
- ex_valid  in  1  EX stage holds a real instruction (0 for bubbles/flushed slots)
- ex_pc  in  ADDR_W  PC of EX instruction
- ex_is_cti  in  1  EX instruction is a branch or jump
- ex_taken  in  1  resolved direction (jumps drive 1)
- ex_target  in  ADDR_W  resolved target
- ex_pred_taken  in  1  prediction made for this instruction, carried down the pipe
- ex_pred_target  in  ADDR_W  if_next_pc recorded for this instruction
- mispredict  out  1  redirect required this cycle
- redirect_pc  out  ADDR_W  correct next PC when mispredict=1
- stat_cti  out  32  count of resolved CTIs
- stat_miss  out  32  count of mispredicts

Behaviour:
- Entry fields: valid, tag[TAG_W], target[ADDR_W], cnt[CNT_BITS].
- Index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]; pc[1:0] ignored.
- Lookup (combinational, zero latency):
  - hit = valid && tag match.
  - if_pred_taken = hit && cnt >= TAKEN_TH.
  - if_next_pc = if_pred_taken ? target : if_pc+4. All adds wrap modulo 2^ADDR_W.
- Resolution (combinational, EX):
  - act_taken = ex_is_cti && ex_taken.
  - act_next = act_taken ? ex_target : ex_pc+4.
  - mispredict = ex_valid && (ex_pred_target != act_next).
  - This covers wrong direction, wrong target, and a non-CTI that was predicted taken (aliased entry).
  - redirect_pc = act_next. redirect_pc is don't-care when mispredict=0, but is still driven as act_next.
- Update (rising edge, only when ex_valid=1):
  - CTI that hits: cnt saturates at +1 if taken (max 2^CNT_BITS-1), at -1 if not taken (min 0); target<=ex_target if taken, else unchanged.
  - CTI that misses and is taken: allocate, overwriting any previous occupant: valid=1, tag, target=ex_target, cnt=TAKEN_TH.
  - CTI that misses and is not taken: no change.
  - Non-CTI that hits: valid<=0 (evict alias).
  - ex_valid=0: no table or stat change.
- Stats:
  - stat_cti += 1 when ex_valid && ex_is_cti.
  - stat_miss += 1 when mispredict.
  - Both wrap at 2^32.
- Simultaneous lookup and update of the same index: lookup returns pre-update contents (no bypass); the new value is visible the following cycle.
- Reset (rst=1 at edge):
  - All valid, cnt, tag and target fields cleared; stats cleared.
  - Outputs next cycle: if_pred_taken=0, if_next_pc=if_pc+4.
  - While rst=1, ex inputs are ignored for table and stat updates.
  - rst mid-run discards all training.
- mispredict/redirect_pc are purely combinational from inputs; the consuming logic flushes IF/ID and ID/EX.
- The table uses flops (no SRAM), so combinational read is legal.

Test Plan:
1. Reset, then if_pc=0x100 -> if_pred_taken=0, if_next_pc=0x104; stat_cti=stat_miss=0.
2. EX: ex_pc=0x100, ex_is_cti=1, ex_taken=1, ex_target=0x80, ex_pred_target=0x104 -> mispredict=1, redirect_pc=0x80, stat_miss=1. Next cycle if_pc=0x100 -> pred_taken=1, next_pc=0x80 (cnt=2).
3. Same branch resolved taken twice with ex_pred_target=0x80 -> mispredict=0 both times; cnt saturates at 3. Then three not-taken resolutions -> prediction flips to not-taken after the second (cnt 3->2->1), cnt=0 after the third; mispredict=1 on the first two (predicted 0x80, actual 0x104), mispredict=0 on the third (predicted 0x104).
4. Alias: ex_pc=0x140 (same index as 0x100 with ENTRIES=16, different tag), taken, target 0x200 -> entry replaced; if_pc=0x100 then misses (next_pc=0x104); a non-CTI at 0x140 with ex_pred_target=0x200 -> mispredict=1, redirect_pc=0x144, entry invalidated.
5. Same-cycle lookup and update of index 0 with a new taken allocation -> that cycle's if_next_pc=if_pc+4; the following cycle shows the new target. ex_valid=0 with otherwise mispredicting inputs -> mispredict=0, no state change.
6. Train 4 entries, assert rst for one cycle mid-stream -> all lookups miss and stats read 0; repeat 1–3 with CNT_BITS=3, ENTRIES=4 (threshold 4, saturation at 7, index pc[3:2]).
